// File: rtl/memory_dumper_if.sv
// Bus bundle between the memory dumper and its surroundings. The master side
// is the dumper: it drives the RAM read address and the display outputs. The
// slave side is the RAM, the control buttons and the display.
interface memory_dumper_if #(
  parameter int ADRS_W = 8,
  parameter int DATA_W = 8
);
  // Control inputs to the dumper
  logic              start;
  logic              stop;
  logic              step;
  logic              auto_mode;

  // RAM read port
  logic [DATA_W-1:0] mm_q;
  logic [ADRS_W-1:0] mm_adrs;
  logic              mm_wr_en;

  // Display and status outputs
  logic [ADRS_W-1:0] dump_adrs;
  logic [DATA_W-1:0] dump_data;
  logic              dump_valid;
  logic              busy;
  logic              done;

  modport master (
    input  start, stop, step, auto_mode, mm_q,
    output mm_adrs, mm_wr_en, dump_adrs, dump_data, dump_valid, busy, done
  );

  modport slave (
    output start, stop, step, auto_mode, mm_q,
    input  mm_adrs, mm_wr_en, dump_adrs, dump_data, dump_valid, busy, done
  );
endinterface

// File: rtl/memory_dumper.sv
// Memory dumper: walks the program RAM from START_ADRS to END_ADRS one word at
// a time and latches each {address, data} pair for the 7-seg display and LEDs.
// Advance is paced by an internal tick (auto_mode=1) or by step pulses.
// Read-only: the RAM write enable is held low permanently.
module memory_dumper #(
  parameter int                ADRS_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [ADRS_W-1:0] START_ADRS = '0,
  parameter logic [ADRS_W-1:0] END_ADRS   = '1,
  parameter int                RD_LAT     = 1,
  parameter int                DIV_TICKS  = 10_000_000
) (
  input  logic            clock,
  input  logic            reset,
  memory_dumper_if.master bus
);

  localparam int WAIT_W = (RD_LAT < 1)    ? 1 : $clog2(RD_LAT + 1);
  localparam int TICK_W = (DIV_TICKS < 2) ? 1 : $clog2(DIV_TICKS);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPT,
    SHOW,
    DONE
  } state_t;

  state_t              state;
  logic [ADRS_W-1:0]   mm_adrs;
  logic [ADRS_W-1:0]   dump_adrs;
  logic [DATA_W-1:0]   dump_data;
  logic                dump_valid;
  logic                busy;
  logic                done;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [TICK_W-1:0]   tick;
  logic                tick_hit;
  logic                adv;

  // A step and an auto tick landing in the same cycle merge into one advance.
  assign tick_hit = bus.auto_mode && (tick == TICK_LAST);
  assign adv      = bus.step || tick_hit;

  // The dumper only reads: the write enable is a constant, not a register.
  assign bus.mm_wr_en   = 1'b0;
  assign bus.mm_adrs    = mm_adrs;
  assign bus.dump_adrs  = dump_adrs;
  assign bus.dump_data  = dump_data;
  assign bus.dump_valid = dump_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;

  // Dump sequencer: state, read address, captured pair, pacing counters and
  // the busy/done flags, all registered together.
  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; a blocking write here would leak into later reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mm_adrs    <= START_ADRS;
      dump_adrs  <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wait_cnt   <= '0;
      tick       <= '0;
    end else if (bus.stop && busy) begin
      // Abort: the last shown pair stays on the display but is flagged stale.
      state      <= IDLE;
      mm_adrs    <= START_ADRS;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // start while busy never reaches here, so a dump cannot restart.
          if (bus.start) begin
            state      <= ISSUE;
            mm_adrs    <= START_ADRS;
            dump_valid <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= WAIT_LOAD;
        end

        WAIT: begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
          if (wait_cnt <= WAIT_W'(1)) begin
            state <= CAPT;
          end
        end

        CAPT: begin
          dump_adrs  <= mm_adrs;
          dump_data  <= bus.mm_q;
          dump_valid <= 1'b1;
          tick       <= '0;
          state      <= SHOW;
        end

        SHOW: begin
          // Turning auto_mode off freezes the tick count instead of clearing it.
          if (bus.auto_mode) begin
            tick <= tick + TICK_W'(1);
          end
          if (adv) begin
            if (mm_adrs == END_ADRS) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              mm_adrs <= mm_adrs + ADRS_W'(1);
              state   <= ISSUE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_dumper.sv
// Directed bench for memory_dumper. Three instances share one RAM image:
// dut_a dumps 00..03 (manual and auto pacing, stop, restart, reset),
// dut_b dumps FD..FF (top-of-range end), dut_c dumps the single word 05.
// Expected pairs are queued when stimulus is driven and compared as the
// DUT captures them.
module tb_memory_dumper;

  typedef struct packed {
    logic [7:0] adrs;
    logic [7:0] data;
  } pair_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:255];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  memory_dumper_if #(.ADRS_W(8), .DATA_W(8)) bus_a ();
  memory_dumper_if #(.ADRS_W(8), .DATA_W(8)) bus_b ();
  memory_dumper_if #(.ADRS_W(8), .DATA_W(8)) bus_c ();

  memory_dumper #(
    .ADRS_W(8), .DATA_W(8), .START_ADRS(8'h00), .END_ADRS(8'h03),
    .RD_LAT(1), .DIV_TICKS(4)
  ) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );

  memory_dumper #(
    .ADRS_W(8), .DATA_W(8), .START_ADRS(8'hFD), .END_ADRS(8'hFF),
    .RD_LAT(1), .DIV_TICKS(4)
  ) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  memory_dumper #(
    .ADRS_W(8), .DATA_W(8), .START_ADRS(8'h05), .END_ADRS(8'h05),
    .RD_LAT(1), .DIV_TICKS(4)
  ) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c)
  );

  // Synchronous RAM model, one cycle clock-to-q, one read port per DUT.
  always @(posedge clock) begin
    bus_a.mm_q <= mem[bus_a.mm_adrs];
    bus_b.mm_q <= mem[bus_b.mm_adrs];
    bus_c.mm_q <= mem[bus_c.mm_adrs];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pair_t mk(input logic [7:0] a);
    return {a, mem[a]};
  endfunction

  // Scoreboards: a capture is a rising dump_valid or a new dump_adrs.
  pair_t      exp_a[$];
  pair_t      exp_b[$];
  int         caps_a = 0, caps_b = 0;
  int         cap_cyc_a = 0;
  logic       pv_a = 1'b0, pv_b = 1'b0;
  logic [7:0] pa_a = 8'h00, pa_b = 8'h00;
  logic       wr_seen = 1'b0;
  logic       b_zero_seen = 1'b0;

  always @(negedge clock) begin
    pair_t p;
    if (bus_a.dump_valid && (!pv_a || bus_a.dump_adrs != pa_a)) begin
      caps_a    <= caps_a + 1;
      cap_cyc_a <= cyc;
      if (exp_a.size() == 0) begin
        check("a_unexpected_capture", exp_a.size(), 1);
      end else begin
        p = exp_a.pop_front();
        check("a_pair", {bus_a.dump_adrs, bus_a.dump_data}, p);
      end
    end
    pv_a <= bus_a.dump_valid;
    pa_a <= bus_a.dump_adrs;
  end

  always @(negedge clock) begin
    pair_t p;
    if (bus_b.dump_valid && (!pv_b || bus_b.dump_adrs != pb_adrs())) begin
      caps_b <= caps_b + 1;
      if (exp_b.size() == 0) begin
        check("b_unexpected_capture", exp_b.size(), 1);
      end else begin
        p = exp_b.pop_front();
        check("b_pair", {bus_b.dump_adrs, bus_b.dump_data}, p);
      end
    end
    pv_b <= bus_b.dump_valid;
    pa_b <= bus_b.dump_adrs;
  end

  function automatic logic [7:0] pb_adrs();
    return pa_b;
  endfunction

  // Sticky flags: any write enable, or dut_b ever addressing 00 (a wrap).
  always @(negedge clock) begin
    if (bus_a.mm_wr_en !== 1'b0 || bus_b.mm_wr_en !== 1'b0 || bus_c.mm_wr_en !== 1'b0)
      wr_seen <= 1'b1;
    if (bus_b.mm_adrs === 8'h00)
      b_zero_seen <= 1'b1;
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_a(input logic s_start, input logic s_stop, input logic s_step);
    bus_a.start = s_start; bus_a.stop = s_stop; bus_a.step = s_step;
    cycle(1);
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.step = 1'b0;
  endtask

  task automatic pulse_b(input logic s_start, input logic s_step);
    bus_b.start = s_start; bus_b.step = s_step;
    cycle(1);
    bus_b.start = 1'b0; bus_b.step = 1'b0;
  endtask

  task automatic pulse_c(input logic s_start, input logic s_step);
    bus_c.start = s_start; bus_c.step = s_step;
    cycle(1);
    bus_c.start = 1'b0; bus_c.step = 1'b0;
  endtask

  task automatic wait_caps(input bit on_b, input int target, input string tag);
    int n = 0;
    while ((on_b ? caps_b : caps_a) < target && n < 40) begin
      cycle(1);
      n++;
    end
    check(tag, on_b ? caps_b : caps_a, target);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) cycle(1);
  endtask

  initial begin
    int c0, c1, c2, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'hA1; mem[8'h02] = 8'hA2; mem[8'h03] = 8'hA3;
    mem[8'hFF] = 8'h5C;
    bus_a.start = 0; bus_a.stop = 0; bus_a.step = 0; bus_a.auto_mode = 0;
    bus_b.start = 0; bus_b.stop = 0; bus_b.step = 0; bus_b.auto_mode = 0;
    bus_c.start = 0; bus_c.stop = 0; bus_c.step = 0; bus_c.auto_mode = 0;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_mm_adrs_a", bus_a.mm_adrs, 8'h00);
    check("rst_mm_adrs_b", bus_b.mm_adrs, 8'hFD);
    check("rst_dump_adrs", bus_a.dump_adrs, 8'h00);
    check("rst_dump_data", bus_a.dump_data, 8'h00);
    check("rst_valid", bus_a.dump_valid, 1'b0);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_done", bus_a.done, 1'b0);
    check("rst_wr_en", bus_a.mm_wr_en, 1'b0);
    cycle(2);
    reset = 1'b0;
    cycle(1);

    // Manual dump of 00..03 with start-to-valid latency
    exp_a.push_back(mk(8'h00));
    pulse_a(1, 0, 0);
    check("lat_mm_adrs", bus_a.mm_adrs, 8'h00);
    check("lat_busy", bus_a.busy, 1'b1);
    check("lat_valid_e1", bus_a.dump_valid, 1'b0);
    cycle(1);
    check("lat_valid_e2", bus_a.dump_valid, 1'b0);
    cycle(1);
    check("lat_valid_e3", bus_a.dump_valid, 1'b0);
    cycle(1);
    check("lat_valid_e4", bus_a.dump_valid, 1'b1);
    wait_caps(0, 1, "caps_first");
    for (int i = 1; i < 4; i++) begin
      exp_a.push_back(mk(8'(i)));
      pulse_a(0, 0, 1);
      wait_caps(0, 1 + i, "caps_manual");
    end
    pulse_a(0, 0, 1);
    check("end_done", bus_a.done, 1'b1);
    check("end_busy", bus_a.busy, 1'b0);
    check("end_dump_adrs", bus_a.dump_adrs, 8'h03);
    pulse_a(0, 0, 1);
    cycle(1);
    check("done_step_ignored", {bus_a.done, bus_a.mm_adrs, bus_a.dump_valid}, {1'b1, 8'h03, 1'b1});

    // New dump from DONE, then stop while waiting on address 02
    exp_a.push_back(mk(8'h00));
    pulse_a(1, 0, 0);
    wait_caps(0, 5, "caps_restart");
    exp_a.push_back(mk(8'h01));
    pulse_a(0, 0, 1);
    wait_caps(0, 6, "caps_pre_stop");
    pulse_a(0, 0, 1);
    check("stop_issue_adrs", bus_a.mm_adrs, 8'h02);
    cycle(1);
    pulse_a(0, 1, 0);
    check("stop_busy", bus_a.busy, 1'b0);
    check("stop_valid", bus_a.dump_valid, 1'b0);
    check("stop_mm_adrs", bus_a.mm_adrs, 8'h00);
    check("stop_kept_pair", {bus_a.dump_adrs, bus_a.dump_data}, {8'h01, 8'hA1});
    cycle(4);
    check("stop_no_capture", caps_a, 6);
    exp_a.push_back(mk(8'h00));
    pulse_a(1, 0, 0);
    wait_caps(0, 7, "caps_after_stop");

    // start and step during WAIT are dropped
    exp_a.push_back(mk(8'h01));
    pulse_a(0, 0, 1);
    cycle(1);
    pulse_a(1, 0, 1);
    wait_caps(0, 8, "caps_wait_ignore");
    cycle(3);
    check("wait_ignore_adrs", {bus_a.mm_adrs, bus_a.dump_adrs, bus_a.busy}, {8'h01, 8'h01, 1'b1});

    // Auto pacing: frozen counter while auto_mode is off, merged step+tick
    pulse_a(0, 1, 0);
    bus_a.auto_mode = 1'b1;
    for (int i = 0; i < 4; i++) exp_a.push_back(mk(8'(i)));
    pulse_a(1, 0, 0);
    wait_caps(0, 9, "caps_auto0");
    c0 = cap_cyc_a;
    wait_cyc(c0 + 2);
    bus_a.auto_mode = 1'b0;
    wait_cyc(c0 + 7);
    bus_a.auto_mode = 1'b1;
    wait_caps(0, 10, "caps_auto1");
    check("auto_hold_period", cap_cyc_a - c0, 12);
    c1 = cap_cyc_a;
    wait_cyc(c1 + 3);
    pulse_a(0, 0, 1);
    wait_caps(0, 11, "caps_auto2");
    check("auto_merge_period", cap_cyc_a - c1, 7);
    c2 = cap_cyc_a;
    wait_caps(0, 12, "caps_auto3");
    check("auto_period", cap_cyc_a - c2, 7);
    n = 0;
    while (!bus_a.done && n < 20) begin cycle(1); n++; end
    check("auto_done", {bus_a.done, bus_a.dump_adrs}, {1'b1, 8'h03});
    bus_a.auto_mode = 1'b0;

    // Top-of-range end address: FD..FF, no wrap to 00
    for (int i = 8'hFD; i <= 8'hFF; i++) exp_b.push_back(mk(8'(i)));
    pulse_b(1, 0);
    wait_caps(1, 1, "caps_b0");
    pulse_b(0, 1);
    wait_caps(1, 2, "caps_b1");
    pulse_b(0, 1);
    wait_caps(1, 3, "caps_b2");
    check("b_last_pair", {bus_b.dump_adrs, bus_b.dump_data}, {8'hFF, 8'h5C});
    pulse_b(0, 1);
    check("b_done", {bus_b.done, bus_b.busy, bus_b.mm_adrs}, {1'b1, 1'b0, 8'hFF});
    pulse_b(0, 1);
    cycle(2);
    check("b_hold_ff", bus_b.mm_adrs, 8'hFF);

    // Single-word range
    pulse_c(1, 0);
    n = 0;
    while (!bus_c.dump_valid && n < 20) begin cycle(1); n++; end
    check("c_pair", {bus_c.dump_valid, bus_c.dump_adrs, bus_c.dump_data}, {1'b1, 8'h05, mem[5]});
    pulse_c(0, 1);
    check("c_done", {bus_c.done, bus_c.busy, bus_c.mm_adrs}, {1'b1, 1'b0, 8'h05});

    // Asynchronous reset while showing a word
    exp_a.push_back(mk(8'h00));
    pulse_a(1, 0, 0);
    wait_caps(0, 13, "caps_pre_reset");
    #2 reset = 1'b1;
    #1;
    check("arst_mm_adrs", bus_a.mm_adrs, 8'h00);
    check("arst_pair", {bus_a.dump_adrs, bus_a.dump_data}, 16'h0000);
    check("arst_flags", {bus_a.dump_valid, bus_a.busy, bus_a.done}, 3'b000);
    check("arst_c_flags", {bus_c.dump_valid, bus_c.done}, 2'b00);
    @(posedge clock);
    #1 reset = 1'b0;
    cycle(1);
    exp_a.push_back(mk(8'h00));
    pulse_a(1, 0, 0);
    wait_caps(0, 14, "caps_post_reset");

    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    check("wr_en_never", wr_seen, 1'b0);
    check("b_never_00", b_zero_seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
